// File: rtl/shift_idex_stage.sv
// Decode-to-execute register for the WISC-SP23 shift unit: decodes shift instructions,
// forwards Rs/Rt from EX/MEM and MEM/WB, and counts issued shifts.
module shift_idex_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [15:0]      instr,
  input  logic [DW-1:0]    rs_data,
  input  logic [DW-1:0]    rt_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             fwd_exmem_en,
  input  logic [2:0]       fwd_exmem_reg,
  input  logic [DW-1:0]    fwd_exmem_data,
  input  logic             fwd_memwb_en,
  input  logic [2:0]       fwd_memwb_reg,
  input  logic [DW-1:0]    fwd_memwb_data,
  output logic             ex_valid,
  output logic             ex_is_shift,
  output logic [DW-1:0]    ex_in,
  output logic [3:0]       ex_bit_cnt,
  output logic [1:0]       ex_op,
  output logic             ex_wr_en,
  output logic [2:0]       ex_wr_reg,
  output logic [CNT_W-1:0] shift_issued
);

  logic [2:0]    rs_idx, rt_idx;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic          is_i_shift, is_r_shift, dec_shift;
  logic [1:0]    dec_op;
  logic [3:0]    dec_cnt;
  logic [2:0]    dec_rd;

  assign rs_idx = instr[10:8];
  assign rt_idx = instr[7:5];

  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    rs_fwd = rs_data;
    if (fwd_exmem_en && (fwd_exmem_reg == rs_idx)) begin
      rs_fwd = fwd_exmem_data;
    end else if (fwd_memwb_en && (fwd_memwb_reg == rs_idx)) begin
      rs_fwd = fwd_memwb_data;
    end
  end

  always_comb begin
    rt_fwd = rt_data;
    if (fwd_exmem_en && (fwd_exmem_reg == rt_idx)) begin
      rt_fwd = fwd_exmem_data;
    end else if (fwd_memwb_en && (fwd_memwb_reg == rt_idx)) begin
      rt_fwd = fwd_memwb_data;
    end
  end

  assign is_i_shift = (instr[15:13] == 3'b101);
  assign is_r_shift = (instr[15:11] == 5'b11010);
  assign dec_shift  = is_i_shift || is_r_shift;

  always_comb begin
    dec_op  = 2'b00;
    dec_cnt = 4'd0;
    dec_rd  = 3'd0;
    if (is_i_shift) begin
      dec_op  = instr[12:11];
      dec_cnt = instr[3:0];
      dec_rd  = instr[7:5];
    end else if (is_r_shift) begin
      dec_op  = instr[1:0];
      dec_cnt = rt_fwd[3:0];
      dec_rd  = instr[4:2];
    end
  end

  logic             valid_q, valid_d;
  logic             is_shift_q, is_shift_d;
  logic [DW-1:0]    in_q, in_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       wr_reg_q, wr_reg_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  always_comb begin
    valid_d    = valid_q;
    is_shift_d = is_shift_q;
    in_d       = in_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    wr_en_d    = wr_en_q;
    wr_reg_d   = wr_reg_q;
    issued_d   = issued_q;
    if (flush) begin
      valid_d    = 1'b0;
      is_shift_d = 1'b0;
      in_d       = '0;
      cnt_d      = 4'd0;
      op_d       = 2'b00;
      wr_en_d    = 1'b0;
      wr_reg_d   = 3'd0;
    end else if (!stall) begin
      valid_d    = id_valid;
      is_shift_d = id_valid && dec_shift;
      in_d       = id_valid ? rs_fwd : '0;
      cnt_d      = id_valid ? dec_cnt : 4'd0;
      op_d       = id_valid ? dec_op : 2'b00;
      wr_en_d    = id_valid && dec_shift;
      wr_reg_d   = id_valid ? dec_rd : 3'd0;
      if (id_valid && dec_shift) begin
        issued_d = issued_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      is_shift_q <= 1'b0;
      in_q       <= '0;
      cnt_q      <= 4'd0;
      op_q       <= 2'b00;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= 3'd0;
      issued_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      is_shift_q <= is_shift_d;
      in_q       <= in_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      issued_q   <= issued_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_is_shift  = is_shift_q;
  assign ex_in        = in_q;
  assign ex_bit_cnt   = cnt_q;
  assign ex_op        = op_q;
  assign ex_wr_en     = wr_en_q;
  assign ex_wr_reg    = wr_reg_q;
  assign shift_issued = issued_q;

endmodule
